// File: rtl/fma16_pkg.sv
// Shared definitions for the fma16 writeback stage: flag layout and the
// sticky-flag update rule.
package fma16_pkg;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    typedef logic [3:0] fflags_t;

    // A software write beats a clear; a result accepted in the same cycle
    // still accrues on top of whichever base wins.
    function automatic fflags_t stickyNext(
        input fflags_t cur,
        input logic    wr,
        input fflags_t wdata,
        input logic    clr,
        input logic    push,
        input fflags_t newFlags
    );
        fflags_t base;
        base = wr ? wdata : (clr ? fflags_t'(0) : cur);
        return base | (push ? newFlags : fflags_t'(0));
    endfunction

endpackage

// File: rtl/fma16_wb_fifo.sv
// Generic DEPTH-entry synchronous FIFO with valid/ready on both sides.
// When empty the output holds the last popped word (zero after reset).
module fma16_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pushValid,
    output logic         pushReady,
    input  logic [W-1:0] pushData,
    output logic         popValid,
    input  logic         popReady,
    output logic [W-1:0] popData,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [W-1:0]     lastPop;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign pushReady = ~full;
    assign popValid  = ~empty;
    assign push      = pushValid & ~full;
    assign pop       = popReady & ~empty;
    assign popData   = empty ? lastPop : mem[rdPtr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
            lastPop <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr   <= rdPtr + 1'b1;
                lastPop <= mem[rdPtr];
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fma16_writeback.sv
// Writeback stage after the fma16 datapath: buffers results, accrues the
// architectural sticky flags at acceptance and counts retired operations.
module fma16_writeback
    import fma16_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_result,
    input  logic [3:0]       in_flags,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_result,
    output logic [3:0]       out_flags,
    output logic [TAG_W-1:0] out_tag,
    input  logic             fflags_clr,
    input  logic             fflags_wr,
    input  logic [3:0]       fflags_wdata,
    output logic [3:0]       fflags,
    output logic [CNT_W-1:0] retired,
    output logic             full,
    output logic             empty
);

    typedef struct packed {
        logic [15:0]      result;
        fflags_t          flags;
        logic [TAG_W-1:0] tag;
    } fma16_wb_entry_t;

    localparam int ENTRY_W = $bits(fma16_wb_entry_t);

    fma16_wb_entry_t inEntry;
    fma16_wb_entry_t headEntry;
    logic            push;
    logic            pop;

    assign inEntry = '{result: in_result, flags: in_flags, tag: in_tag};

    fma16_wb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .pushValid (in_valid),
        .pushReady (in_ready),
        .pushData  (inEntry),
        .popValid  (out_valid),
        .popReady  (out_ready),
        .popData   (headEntry),
        .full      (full),
        .empty     (empty)
    );

    assign out_result = headEntry.result;
    assign out_flags  = headEntry.flags;
    assign out_tag    = headEntry.tag;
    assign push       = in_valid & in_ready;
    assign pop        = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fflags  <= '0;
            retired <= '0;
        end else begin
            fflags <= stickyNext(fflags, fflags_wr, fflags_wdata, fflags_clr, push, in_flags);
            if (pop) begin
                retired <= retired + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_fma16_writeback.sv
// Scoreboard bench for fma16_writeback: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fma16_writeback;

    localparam int DEPTH = 2;
    localparam int TAG_W = 4;
    localparam int CNT_W = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_result;
    logic [3:0]       in_flags;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_result;
    logic [3:0]       out_flags;
    logic [TAG_W-1:0] out_tag;
    logic             fflags_clr;
    logic             fflags_wr;
    logic [3:0]       fflags_wdata;
    logic [3:0]       fflags;
    logic [CNT_W-1:0] retired;
    logic             full;
    logic             empty;

    fma16_writeback #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .out_tag      (out_tag),
        .fflags_clr   (fflags_clr),
        .fflags_wr    (fflags_wr),
        .fflags_wdata (fflags_wdata),
        .fflags       (fflags),
        .retired      (retired),
        .full         (full),
        .empty        (empty)
    );

    typedef struct {
        logic [15:0]      r;
        logic [3:0]       f;
        logic [TAG_W-1:0] t;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    ent_t q[$];
    ent_t lastM;
    logic [3:0] fflM;
    int   retM;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of accepted entries, updated at each negedge from
    // the inputs that will be seen by the coming rising edge.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            lastM = '{r: 16'h0, f: 4'h0, t: '0};
            fflM  = 4'h0;
            retM  = 0;
        end else begin
            logic doPush;
            logic doPop;
            ent_t e;
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("full", full, q.size() == DEPTH);
            chk("empty", empty, q.size() == 0);
            chk("out_valid", out_valid, q.size() != 0);
            chk("fflags", fflags, fflM);
            chk("retired", retired, retM % (1 << CNT_W));
            if (q.size() != 0) begin
                chk("head_result", out_result, q[0].r);
                chk("head_flags", out_flags, q[0].f);
                chk("head_tag", out_tag, q[0].t);
            end else begin
                chk("idle_result", out_result, lastM.r);
                chk("idle_flags", out_flags, lastM.f);
                chk("idle_tag", out_tag, lastM.t);
            end
            doPush = in_valid && (q.size() < DEPTH);
            doPop  = out_ready && (q.size() != 0);
            if (fflags_wr)       fflM = fflags_wdata;
            else if (fflags_clr) fflM = 4'h0;
            if (doPush)          fflM = fflM | in_flags;
            if (doPop) begin
                lastM = q.pop_front();
                retM  = retM + 1;
            end
            if (doPush) begin
                e.r = in_result;
                e.f = in_flags;
                e.t = in_tag;
                q.push_back(e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendOne(input logic [15:0] r, input logic [3:0] f, input logic [TAG_W-1:0] t);
        in_valid  = 1'b1;
        in_result = r;
        in_flags  = f;
        in_tag    = t;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (empty) return;
            tick();
        end
        chk("drain_timeout", 0, 1);
    endtask

    initial begin
        logic [CNT_W-1:0] r0;
        logic [CNT_W-1:0] diff;
        logic             acc;
        reset = 1'b1;
        in_valid = 1'b0; in_result = '0; in_flags = '0; in_tag = '0;
        out_ready = 1'b0;
        fflags_clr = 1'b0; fflags_wr = 1'b0; fflags_wdata = '0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_out", {out_result, out_flags, out_tag}, 0);
        tick(); tick();
        reset = 1'b0;
        tick();

        // single pass
        out_ready = 1'b1;
        sendOne(16'h3C00, 4'b0001, 4'd3);
        chk("sp_valid", out_valid, 1);
        chk("sp_result", out_result, 16'h3C00);
        chk("sp_flags", out_flags, 4'b0001);
        chk("sp_tag", out_tag, 3);
        chk("sp_fflags", fflags, 4'b0001);
        tick();
        chk("sp_retired", retired, 1);

        // reset mid-operation
        out_ready = 1'b0;
        sendOne(16'h1111, 4'b1010, 4'd1);
        sendOne(16'h2222, 4'b0100, 4'd2);
        chk("rm_full_before", full, 1);
        #2 reset = 1'b1;
        #1;
        chk("rm_out_valid", out_valid, 0);
        chk("rm_empty", empty, 1);
        chk("rm_fflags", fflags, 0);
        chk("rm_retired", retired, 0);
        chk("rm_out", {out_result, out_flags, out_tag}, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("rm_in_ready", in_ready, 1);
        tick();

        // backpressure
        out_ready = 1'b0;
        sendOne(16'h4000, 4'b0000, 4'd4);
        sendOne(16'h4200, 4'b0000, 4'd5);
        chk("bp_full", full, 1);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 1'b1; in_result = 16'h4400; in_flags = 4'b0010; in_tag = 4'd6;
        tick(); tick(); tick();
        chk("bp_still_full", full, 1);
        chk("bp_head_held", out_result, 16'h4000);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        chk("bp_accepted", acc, 1);
        in_valid = 1'b0;
        drain();

        // simultaneous push and pop at occupancy 1
        out_ready = 1'b0;
        sendOne(16'h5000, 4'b0000, 4'd0);
        r0 = retired;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_result = 16'h5000 + 16'(k);
            in_tag = TAG_W'(k);
            tick();
            chk("sim_occ1", {out_valid, full}, 2'b10);
        end
        in_valid = 1'b0;
        diff = retired - r0;
        chk("sim_retired", diff, 8);
        drain();

        // flag priority
        fflags_wr = 1'b1; fflags_wdata = 4'b1000;
        tick();
        fflags_wr = 1'b0;
        chk("fp_write", fflags, 4'b1000);
        fflags_clr = 1'b1;
        in_valid = 1'b1; in_flags = 4'b0100; in_result = 16'h6000; in_tag = 4'd9;
        tick();
        chk("fp_clr_push", fflags, 4'b0100);
        fflags_wr = 1'b1; fflags_wdata = 4'b0010;
        in_flags = 4'b0001; in_result = 16'h6100; in_tag = 4'd10;
        tick();
        in_valid = 1'b0; fflags_wr = 1'b0; fflags_clr = 1'b0;
        chk("fp_wr_beats_clr", fflags, 4'b0011);
        drain();

        // counter wrap
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) sendOne(16'h7000 + 16'(k), 4'b0000, TAG_W'(k));
        drain();
        tick();
        chk("wrap_retired", retired, 1);

        // random traffic
        acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || acc) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                in_result = 16'($urandom);
                in_flags  = 4'($urandom);
                in_tag    = TAG_W'($urandom);
            end
            out_ready    = ($urandom_range(0, 2) != 0);
            fflags_clr   = ($urandom_range(0, 9) == 0);
            fflags_wr    = ($urandom_range(0, 9) == 0);
            fflags_wdata = 4'($urandom);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
        end
        in_valid = 1'b0; fflags_clr = 1'b0; fflags_wr = 1'b0;
        drain();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
